// File: rtl/cpu_seq_ctrl_if.sv
// Control-plane bundle between the program sequencer and the register/ALU datapath.
// The sequencer is the master; the datapath side (and instruction ROM) is the slave.
interface cpu_seq_ctrl_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic [15:0]     imem_data;
  logic [PC_W-1:0] imem_addr;
  logic            en_inst;
  logic [3:0]      mux_sel;
  logic [2:0]      sel;
  logic            en_s;
  logic            en_c;
  logic [7:0]      en;
  logic            done;
  logic            halted;
  logic            busy;

  modport master (
    input  run, imem_data,
    output imem_addr, en_inst, mux_sel, sel, en_s, en_c, en, done, halted, busy
  );

  modport slave (
    output run, imem_data,
    input  imem_addr, en_inst, mux_sel, sel, en_s, en_c, en, done, halted, busy
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Autonomous program sequencer: fetches 16-bit instructions from a sync ROM,
// decodes them and drives the register-file / ALU datapath controls until HALT.
module cpu_seq_ctrl #(
  parameter int PC_W     = 8,
  parameter int START_PC = 0
) (
  input  logic           clk,
  input  logic           reset,
  cpu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC_A, EXEC_B, WB, HALT
  } state_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_MOV  = 2'b01;
  localparam logic [1:0] CLS_HALT = 2'b11;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [2:0] rd, rb, op;
  logic [1:0] cls;
  logic       unused_ir_bits;

  logic       en_inst, en_s, en_c, done, halted, busy;
  logic [3:0] mux_sel;
  logic [2:0] sel;
  logic [7:0] en_w;

  assign rd  = ir_q[15:13];
  assign rb  = ir_q[12:10];
  assign op  = ir_q[4:2];
  assign cls = ir_q[1:0];
  // Reserved field is latched into ir but never decoded.
  assign unused_ir_bits = ^ir_q[9:5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(START_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    en_inst = 1'b0;
    mux_sel = 4'd0;
    sel     = 3'd0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en_w    = 8'd0;
    done    = 1'b0;
    halted  = 1'b0;
    busy    = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        // ROM word addressed in FETCH is valid now; branch on its class directly.
        en_inst = 1'b1;
        ir_d    = bus.imem_data;
        pc_d    = pc_q + PC_W'(1);
        case (bus.imem_data[1:0])
          CLS_ALU:  state_d = EXEC_A;
          CLS_HALT: state_d = HALT;
          default:  state_d = WB;
        endcase
      end
      EXEC_A: begin
        en_s    = 1'b1;
        mux_sel = {1'b0, rd};
        state_d = EXEC_B;
      end
      EXEC_B: begin
        en_c    = 1'b1;
        mux_sel = {1'b0, rb};
        sel     = op;
        state_d = WB;
      end
      WB: begin
        en_w = 8'd1 << rd;
        done = 1'b1;
        case (cls)
          CLS_ALU: mux_sel = 4'd9;
          CLS_MOV: mux_sel = {1'b0, rb};
          default: mux_sel = 4'd8;
        endcase
        state_d = bus.run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
        busy   = 1'b0;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.en_inst   = en_inst;
  assign bus.mux_sel   = mux_sel;
  assign bus.sel       = sel;
  assign bus.en_s      = en_s;
  assign bus.en_c      = en_c;
  assign bus.en        = en_w;
  assign bus.done      = done;
  assign bus.halted    = halted;
  assign bus.busy      = busy;

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Program-sequencing controller for the 8-register / ALU datapath.
- Fetches 16-bit instructions from a synchronous instruction ROM through an internal program counter and decodes them.
- Drives the datapath controls: register-file enables, operand bus mux, ALU select, operand/result latch enables and IR load.
- Runs programs autonomously until a HALT instruction, replacing per-instruction external stepping.

Parameters:
- PC_W, 8, width of program counter / instruction address; PC wraps modulo 2^PC_W.
- START_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; enables fetching of new instructions.
- imem_data  input  16  instruction word; valid one cycle after imem_addr is presented (sync ROM).
- imem_addr  output  PC_W  instruction fetch address (= pc).
- en_inst  output  1  load strobe for datapath instruction register.
- mux_sel  output  4  bus mux: 0-7 register Rn, 8 external data input, 9 ALU result latch C; 10-15 unused.
- sel  output  3  ALU operation select.
- en_s  output  1  operand-A latch enable.
- en_c  output  1  ALU result latch enable.
- en  output  8  one-hot register-file write enables.
- done  output  1  high during the writeback cycle of every completed instruction.
- halted  output  1  high while in HALT state.
- busy  output  1  high in any state other than IDLE and HALT.

Behaviour:
- Instruction fields: [15:13] rd, [12:10] rb, [9:5] reserved and ignored, [4:2] alu op, [1:0] class.
- Class values: 00 ALU (rd <= rd op rb), 01 MOV (rd <= rb), 10 LDX (rd <= external data), 11 HALT.
- Internal registers: state, pc[PC_W], ir[16].
- Outputs are Moore decodes of state and ir. Any output not listed for a state is 0.
- Reset (async, any state):
  - state=IDLE, pc=START_PC, ir=0.
  - All outputs 0 immediately, except imem_addr=START_PC.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: imem_addr=pc; -> DECODE.
- DECODE:
  - en_inst=1; ir<=imem_data; pc<=pc+1 (wraps 2^PC_W-1 -> 0).
  - -> EXEC_A when imem_data class is 00, HALT when 11, WB otherwise.
- EXEC_A: en_s=1, mux_sel={0,rd}; -> EXEC_B.
- EXEC_B: en_c=1, mux_sel={0,rb}, sel=op; -> WB.
- WB:
  - en[rd]=1 (exactly one bit set), done=1.
  - mux_sel: 9 for ALU, {0,rb} for MOV, 8 for LDX.
  - Next state: run=1 -> FETCH, run=0 -> IDLE.
- HALT:
  - halted=1; stay until reset; run ignored.
  - HALT does not assert done.
  - pc already points past the HALT word.
- Latency from FETCH entry to done: ALU 5 cycles (FETCH, DECODE, EXEC_A, EXEC_B, WB); MOV/LDX 3 cycles.
- run deasserted mid-instruction: the instruction completes normally; IDLE is entered after WB.
- run is sampled only in IDLE and WB.
- Back-to-back instructions with run held high: WB is followed directly by FETCH, with no idle cycle.
- MOV with rd==rb: legal; en[rd]=1, mux_sel=rd.
- ALU with rd==rb: legal; same sequence.
- Reset asserted mid-instruction aborts the instruction: no en bit or done observed after the reset edge.
- en is never multi-hot; en_s, en_c, en_inst and en are mutually exclusive in time.

Test Plan:
- ALU timing: reset, ROM[0]=16'h280C (rd=1, rb=2, op=3), run=1.
  - Cycle 1 FETCH: imem_addr=0.
  - Cycle 2 DECODE: en_inst=1.
  - Cycle 3 EXEC_A: en_s=1, mux_sel=1.
  - Cycle 4 EXEC_B: en_c=1, mux_sel=2, sel=3.
  - Cycle 5 WB: en=8'h02, mux_sel=9, done=1.
- MOV then LDX: ROM[0]=16'h7401, ROM[1]=16'hE002, run=1.
  - MOV WB: en=8'h08, mux_sel=5, done=1.
  - LDX WB: en=8'h80, mux_sel=8, done=1.
  - Total 6 cycles, no gaps between instructions.
- HALT: ROM[0]=16'h7401, ROM[1]=16'h0003.
  - Ends with halted=1, busy=0, pc=2, no further fetches.
  - Toggling run leaves the block in HALT; reset returns it to IDLE, pc=0.
- Run drop: run falls during EXEC_A of 16'h280C.
  - Instruction still reaches WB with done=1, then IDLE.
  - Raising run two cycles later resumes at FETCH with imem_addr=1.
- Wrap: PC_W=2, ROM of four MOVs.
  - After the 4th DECODE pc=0; the 5th FETCH uses imem_addr=0.
- Async reset: assert reset mid-cycle during EXEC_B.
  - en_c, sel and mux_sel drop to 0 before the next clock edge.
  - No done follows; state=IDLE.
